ttc_test_generator: RTL and testbench

- Local TTC command source for bench and standalone running. Produces the single-cycle l1a / bc0 / resync / vfat_reset pulses that the LED and TTC-consuming logic receive.
- Emulates the LHC orbit structure and provides periodic and burst L1A generation.
- A resync state machine enforces a holdoff window after each resync.
- Sits in the control domain beside the TTC decoder. Its outputs are muxed in place of the decoded TTC signals when local mode is selected.

---
 rtl/ttc_test_generator.sv | 175 +++++++++++++++++
 tb/tb_ttc_test_generator.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttc_test_generator.sv
// Local TTC command source: emulates the LHC orbit and generates bc0, periodic/burst L1A,
// resync (with holdoff) and vfat_reset pulses for standalone running.
module ttc_test_generator #(
  parameter int BX_PER_ORBIT    = 3564,
  parameter int BC0_BX          = 0,
  parameter int RESYNC_BX       = 100,
  parameter int RESYNC_HOLDOFF  = 64,
  parameter int L1A_MIN_SPACING = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_i,
  input  logic [23:0] l1a_period_i,
  input  logic        l1a_burst_req_i,
  input  logic [7:0]  l1a_burst_len_i,
  input  logic        resync_req_i,
  input  logic        vfat_reset_req_i,
  output logic        ttc_l1a_o,
  output logic        ttc_bc0_o,
  output logic        ttc_resync_o,
  output logic        vfat_reset_o,
  output logic        resync_ack_o,
  output logic        busy_o,
  output logic [11:0] bx_cnt_o,
  output logic [15:0] orbit_cnt_o,
  output logic [31:0] l1a_cnt_o
);

  localparam int BX_W   = 12;
  localparam int HOLD_W = $clog2(RESYNC_HOLDOFF + 1);
  localparam int GAP_W  = $clog2(L1A_MIN_SPACING + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FIRE, S_HOLDOFF} state_t;

  state_t              r_state, w_state_next;
  logic                r_pending, w_pending_next;
  logic [HOLD_W-1:0]   r_hold, w_hold_next;
  logic [BX_W-1:0]     r_bx;
  logic [15:0]         r_orbit;
  logic [23:0]         r_period, r_pcnt;
  logic [7:0]          r_burst_rem;
  logic [GAP_W-1:0]    r_gap;
  logic [31:0]         r_l1a_cnt;
  logic                r_l1a, r_bc0, r_resync, r_ack, r_vfat, r_vfat_prev;

  logic w_fire, w_to_fire, w_l1a_ok, w_ptrig, w_burst_issue, w_issue;

  assign w_fire        = (r_state == S_FIRE);
  assign w_to_fire     = (r_state == S_WAIT) && (r_bx == BX_W'(RESYNC_BX));
  assign w_l1a_ok      = enable_i && ((r_state == S_IDLE) || (r_state == S_WAIT)) && (r_gap == '0);
  assign w_ptrig       = (r_period != '0) && (r_pcnt == r_period - 24'd1);
  assign w_burst_issue = w_l1a_ok && (r_burst_rem != '0);
  assign w_issue       = w_l1a_ok && ((r_burst_rem != '0) || w_ptrig);

  always_comb begin
    w_state_next   = r_state;
    w_pending_next = r_pending;
    w_hold_next    = r_hold;
    case (r_state)
      S_IDLE: begin
        if (resync_req_i || r_pending) begin
          w_state_next   = S_WAIT;
          w_pending_next = 1'b0;
        end
      end
      S_WAIT: begin
        if (w_to_fire) w_state_next = S_FIRE;
      end
      S_FIRE: begin
        w_state_next = S_HOLDOFF;
        w_hold_next  = '0;
        if (resync_req_i) w_pending_next = 1'b1;
      end
      S_HOLDOFF: begin
        if (resync_req_i) w_pending_next = 1'b1;
        if (r_hold == HOLD_W'(RESYNC_HOLDOFF - 1)) w_state_next = S_IDLE;
        else w_hold_next = r_hold + HOLD_W'(1);
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_pending <= 1'b0;
      r_hold    <= '0;
    end else begin
      r_state   <= w_state_next;
      r_pending <= w_pending_next;
      r_hold    <= w_hold_next;
    end
  end

  // Orbit counters free-run; leaving FIRE realigns them to BX 0 of orbit 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bx    <= '0;
      r_orbit <= '0;
    end else if (w_fire) begin
      r_bx    <= '0;
      r_orbit <= '0;
    end else if (r_bx == BX_W'(BX_PER_ORBIT - 1)) begin
      r_bx    <= '0;
      r_orbit <= r_orbit + 16'd1;
    end else begin
      r_bx <= r_bx + BX_W'(1);
    end
  end

  // The period is latched only at reload so a mid-cycle change cannot truncate a period.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_period <= '0;
      r_pcnt   <= '0;
    end else if ((r_period == '0) || w_ptrig) begin
      r_pcnt   <= '0;
      r_period <= l1a_period_i;
    end else begin
      r_pcnt <= r_pcnt + 24'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_burst_rem <= '0;
      r_gap       <= '0;
      r_l1a_cnt   <= '0;
    end else begin
      if (w_issue) r_gap <= GAP_W'(L1A_MIN_SPACING - 1);
      else if (r_gap != '0) r_gap <= r_gap - GAP_W'(1);
      if (w_fire) begin
        r_burst_rem <= '0;
        r_l1a_cnt   <= '0;
      end else begin
        if (w_issue) r_l1a_cnt <= r_l1a_cnt + 32'd1;
        // Loading a zero length leaves the burst idle, which drops the request.
        if (r_burst_rem == '0) begin
          if (l1a_burst_req_i) r_burst_rem <= l1a_burst_len_i;
        end else if (w_burst_issue) begin
          r_burst_rem <= r_burst_rem - 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_l1a       <= 1'b0;
      r_bc0       <= 1'b0;
      r_resync    <= 1'b0;
      r_ack       <= 1'b0;
      r_vfat      <= 1'b0;
      r_vfat_prev <= 1'b0;
    end else begin
      r_l1a       <= w_issue;
      r_bc0       <= enable_i && (r_bx == BX_W'(BC0_BX));
      r_resync    <= enable_i && w_to_fire;
      r_ack       <= w_to_fire;
      r_vfat      <= enable_i && vfat_reset_req_i && !r_vfat_prev;
      r_vfat_prev <= vfat_reset_req_i;
    end
  end

  assign ttc_l1a_o    = r_l1a;
  assign ttc_bc0_o    = r_bc0;
  assign ttc_resync_o = r_resync;
  assign resync_ack_o = r_ack;
  assign vfat_reset_o = r_vfat;
  assign busy_o       = (r_state != S_IDLE) || (r_burst_rem != '0);
  assign bx_cnt_o     = r_bx;
  assign orbit_cnt_o  = r_orbit;
  assign l1a_cnt_o    = r_l1a_cnt;

endmodule

// File: tb/tb_ttc_test_generator.sv
// Directed bench for ttc_test_generator: orbit/bc0, periodic and burst L1A,
// resync holdoff, reset recovery and enable gating.
module tb_ttc_test_generator;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        enable_i = 1'b0;
  logic [23:0] l1a_period_i = '0;
  logic        l1a_burst_req_i = 1'b0;
  logic [7:0]  l1a_burst_len_i = '0;
  logic        resync_req_i = 1'b0;
  logic        vfat_reset_req_i = 1'b0;
  logic        ttc_l1a_o, ttc_bc0_o, ttc_resync_o, vfat_reset_o, resync_ack_o, busy_o;
  logic [11:0] bx_cnt_o;
  logic [15:0] orbit_cnt_o;
  logic [31:0] l1a_cnt_o;

  int checks = 0;
  int errors = 0;
  int cnt, bad, busyBad, other, last, first, found, b0;
  logic [31:0] startCnt;

  ttc_test_generator dut (
    .clock            (clock),
    .reset            (reset),
    .enable_i         (enable_i),
    .l1a_period_i     (l1a_period_i),
    .l1a_burst_req_i  (l1a_burst_req_i),
    .l1a_burst_len_i  (l1a_burst_len_i),
    .resync_req_i     (resync_req_i),
    .vfat_reset_req_i (vfat_reset_req_i),
    .ttc_l1a_o        (ttc_l1a_o),
    .ttc_bc0_o        (ttc_bc0_o),
    .ttc_resync_o     (ttc_resync_o),
    .vfat_reset_o     (vfat_reset_o),
    .resync_ack_o     (resync_ack_o),
    .busy_o           (busy_o),
    .bx_cnt_o         (bx_cnt_o),
    .orbit_cnt_o      (orbit_cnt_o),
    .l1a_cnt_o        (l1a_cnt_o)
  );

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic waitResync(input string tag);
    found = 0;
    for (int k = 0; k < 4000 && found == 0; k++) begin
      applyStimulus(1);
      if (ttc_resync_o) found = 1;
    end
    checkOutput(tag, found, 1);
  endtask

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    enable_i = 1'b1;
    applyStimulus(3);
    checkOutput("rst_bx", 32'(bx_cnt_o), 0);
    checkOutput("rst_orbit", 32'(orbit_cnt_o), 0);
    checkOutput("rst_l1acnt", l1a_cnt_o, 0);
    checkOutput("rst_pulses", 32'({ttc_l1a_o, ttc_bc0_o, ttc_resync_o, vfat_reset_o, resync_ack_o, busy_o}), 0);

    $display("[TB] orbit and bc0");
    reset = 1'b1;
    bad = 0; cnt = 0; other = 0;
    for (int k = 1; k <= 3 * 3564; k++) begin
      applyStimulus(1);
      if (k == 1) begin
        checkOutput("bc0_first", 32'(ttc_bc0_o), 1);
        checkOutput("bx_first", 32'(bx_cnt_o), 1);
      end
      if (ttc_bc0_o !== ((k % 3564) == 1)) bad++;
      cnt += int'(ttc_bc0_o);
      other += int'(ttc_l1a_o | ttc_resync_o | vfat_reset_o | resync_ack_o);
    end
    checkOutput("bc0_pattern", bad, 0);
    checkOutput("bc0_count", cnt, 3);
    checkOutput("orbit_3", 32'(orbit_cnt_o), 3);
    checkOutput("bx_wrap", 32'(bx_cnt_o), 0);
    checkOutput("no_other_pulses", other, 0);

    $display("[TB] vfat_reset edge");
    vfat_reset_req_i = 1'b1;
    applyStimulus(1);
    checkOutput("vfat_pulse", 32'(vfat_reset_o), 1);
    applyStimulus(1);
    checkOutput("vfat_single", 32'(vfat_reset_o), 0);
    vfat_reset_req_i = 1'b0;

    $display("[TB] periodic L1A");
    l1a_period_i = 24'd10;
    applyStimulus(30);
    startCnt = l1a_cnt_o; cnt = 0; bad = 0; last = -1;
    for (int k = 0; k < 1000; k++) begin
      applyStimulus(1);
      if (ttc_l1a_o) begin
        cnt++;
        if (last >= 0 && k - last != 10) bad++;
        last = k;
      end
    end
    checkOutput("per10_count", cnt, 100);
    checkOutput("per10_spacing", bad, 0);
    checkOutput("per10_l1acnt", l1a_cnt_o - startCnt, 100);

    l1a_period_i = 24'd2;
    applyStimulus(30);
    cnt = 0; bad = 0; last = -1;
    for (int k = 0; k < 100; k++) begin
      applyStimulus(1);
      if (ttc_l1a_o) begin
        cnt++;
        if (last >= 0 && k - last != 4) bad++;
        last = k;
      end
    end
    checkOutput("per2_count", cnt, 25);
    checkOutput("per2_spacing", bad, 0);

    l1a_period_i = 24'd0;
    applyStimulus(20);
    cnt = 0;
    for (int k = 0; k < 50; k++) begin
      applyStimulus(1);
      cnt += int'(ttc_l1a_o);
    end
    checkOutput("per0_none", cnt, 0);

    $display("[TB] burst");
    startCnt = l1a_cnt_o;
    l1a_burst_req_i = 1'b1; l1a_burst_len_i = 8'd5;
    cnt = 0; bad = 0; busyBad = 0; last = -1; first = -1;
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1);
      if (k == 1) l1a_burst_req_i = 1'b0;
      if (k == 4) begin l1a_burst_req_i = 1'b1; l1a_burst_len_i = 8'd7; end
      if (k == 5) l1a_burst_req_i = 1'b0;
      if (ttc_l1a_o) begin
        cnt++;
        if (first < 0) first = k;
        if (last >= 0 && k - last != 3) bad++;
        last = k;
      end
      if (cnt < 5 && busy_o !== 1'b1) busyBad++;
    end
    checkOutput("burst_first", first, 2);
    checkOutput("burst_count", cnt, 5);
    checkOutput("burst_spacing", bad, 0);
    checkOutput("burst_busy", busyBad, 0);
    checkOutput("burst_done_busy", 32'(busy_o), 0);
    checkOutput("burst_l1acnt", l1a_cnt_o - startCnt, 5);

    l1a_burst_req_i = 1'b1; l1a_burst_len_i = 8'd0;
    applyStimulus(1);
    l1a_burst_req_i = 1'b0;
    applyStimulus(1);
    checkOutput("burst0_busy", 32'(busy_o), 0);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1);
      cnt += int'(ttc_l1a_o);
    end
    checkOutput("burst0_none", cnt, 0);

    $display("[TB] resync");
    l1a_period_i = 24'd10;
    found = 0;
    for (int k = 0; k < 4000 && found == 0; k++) begin
      applyStimulus(1);
      if (bx_cnt_o == 12'd50) found = 1;
    end
    checkOutput("wait_bx50", found, 1);
    resync_req_i = 1'b1;
    applyStimulus(1);
    resync_req_i = 1'b0;
    waitResync("resync1_seen");
    checkOutput("resync1_bx", 32'(bx_cnt_o), 101);
    checkOutput("resync1_ack", 32'(resync_ack_o), 1);
    checkOutput("pre_clear_l1acnt_nz", 32'(l1a_cnt_o != 0), 1);
    applyStimulus(1);
    checkOutput("post_resync_bx", 32'(bx_cnt_o), 0);
    checkOutput("post_resync_l1acnt", l1a_cnt_o, 0);
    checkOutput("post_resync_orbit", 32'(orbit_cnt_o), 0);
    cnt = 0;
    for (int k = 0; k < 64; k++) begin
      if (k > 0) applyStimulus(1);
      cnt += int'(ttc_l1a_o);
      if (k == 10) resync_req_i = 1'b1;
      if (k == 11) resync_req_i = 1'b0;
    end
    checkOutput("holdoff_no_l1a", cnt, 0);
    waitResync("resync2_seen");
    checkOutput("resync2_bx", 32'(bx_cnt_o), 101);
    checkOutput("resync2_orbit", 32'(orbit_cnt_o), 0);
    applyStimulus(80);
    checkOutput("resync2_idle", 32'(busy_o), 0);

    $display("[TB] reset during holdoff and burst");
    l1a_period_i = 24'd0;
    resync_req_i = 1'b1;
    applyStimulus(1);
    resync_req_i = 1'b0;
    waitResync("resync3_seen");
    applyStimulus(1);
    l1a_burst_req_i = 1'b1; l1a_burst_len_i = 8'd200; resync_req_i = 1'b1;
    applyStimulus(1);
    l1a_burst_req_i = 1'b0; resync_req_i = 1'b0;
    applyStimulus(5);
    checkOutput("pre_reset_busy", 32'(busy_o), 1);
    reset = 1'b0;
    #1;
    checkOutput("async_rst_pulses", 32'({ttc_l1a_o, ttc_bc0_o, ttc_resync_o, vfat_reset_o, resync_ack_o, busy_o}), 0);
    checkOutput("async_rst_bx", 32'(bx_cnt_o), 0);
    checkOutput("async_rst_orbit", 32'(orbit_cnt_o), 0);
    checkOutput("async_rst_l1acnt", l1a_cnt_o, 0);
    applyStimulus(2);
    reset = 1'b1;
    cnt = 0; other = 0;
    for (int k = 0; k < 4000; k++) begin
      applyStimulus(1);
      cnt += int'(ttc_resync_o | resync_ack_o);
      other += int'(ttc_l1a_o | busy_o);
    end
    checkOutput("no_resync_after_reset", cnt, 0);
    checkOutput("no_burst_after_reset", other, 0);

    $display("[TB] enable gating");
    enable_i = 1'b0;
    l1a_period_i = 24'd10;
    l1a_burst_req_i = 1'b1; l1a_burst_len_i = 8'd5;
    b0 = int'(bx_cnt_o);
    cnt = 0;
    for (int k = 1; k <= 200; k++) begin
      applyStimulus(1);
      if (k == 1) begin l1a_burst_req_i = 1'b0; vfat_reset_req_i = 1'b1; end
      cnt += int'(ttc_l1a_o | ttc_bc0_o | ttc_resync_o | vfat_reset_o);
    end
    checkOutput("disabled_no_pulses", cnt, 0);
    checkOutput("disabled_bx_runs", 32'(bx_cnt_o), 32'((b0 + 200) % 3564));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
